imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational immediate generator. Sits between fetch and decode.
//  Takes {IR, tag} under valid/ready. Returns the sign- or zero-extended XLEN immediate, a format code and an illegal flag.
//  Adds XLEN 32/64 support, shamt/CSR-zimm handling, a 2-entry skid buffer, flush, and a saturating illegal counter.
// PARAMETERS
//  XLEN   32  immediate width; legal values are 32 or 64 only
//  TAG_W  8   width of the sideband tag (PC index/ROB id), passed through unchanged
//  CNT_W  16  width of the illegal-instruction counter
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      reset, asynchronous, active-high
//  flush        in   1      synchronous pipeline kill
//  in_valid     in   1      input instruction valid
//  in_ready     out  1      block can accept an input this cycle
//  in_ir        in   32     instruction word
//  in_tag       in   TAG_W  sideband tag
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts the result
//  out_imm      out  XLEN   immediate
//  out_fmt      out  3      format: 0=R 1=I 2=S 3=B 4=U 5=J 6=Z(zimm) 7=X(illegal)
//  out_illegal  out  1      opcode not recognised, or IR[1:0]!=2'b11
//  out_tag      out  TAG_W  tag of the result
//  illegal_cnt  out  CNT_W  count of illegal results delivered; saturates at all-ones
// BEHAVIOUR
//  Reset: out_valid=0, skid empty, in_ready=1, out_imm=0, out_fmt=7, out_illegal=0, out_tag=0, illegal_cnt=0.
//  Decode is combinational on in_ir; the result is captured at the handshake. Latency is 1 cycle (accept at edge N, out_valid at N+1).
//  Decode by opcode IR[6:0]. s = sign-extend to XLEN, z = zero-extend to XLEN.
//   0010011 OP-IMM: funct3 001/101 -> z(shamt), fmt I. shamt=IR[24:20] for XLEN=32, IR[25:20] for XLEN=64.
//      All other funct3 -> s(IR[31:20]), fmt I.
//   0011011 OP-IMM-32: legal only when XLEN=64; same rules as OP-IMM but shamt=IR[24:20]. Illegal when XLEN=32.
//   0000011 LOAD, 1100111 JALR -> s(IR[31:20]), fmt I.   0001111 MISC-MEM -> s(IR[31:20]), fmt I.
//   0100011 STORE -> s({IR[31:25],IR[11:7]}), fmt S.
//   1100011 BRANCH -> s({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}), fmt B.
//   0110111 LUI, 0010111 AUIPC -> s({IR[31:12],12'b0}), fmt U. Sign-extends to bit 63 when XLEN=64.
//   1101111 JAL -> s({IR[31],IR[19:12],IR[20],IR[30:21],1'b0}), fmt J.
//   1110011 SYSTEM: funct3[2]=1 -> z(IR[19:15]), fmt Z. Otherwise z(IR[31:20]) (CSR address), fmt I.
//   0110011 OP, 0111011 OP-32 (XLEN=64 only) -> imm 0, fmt R.
//   Anything else, or IR[1:0]!=11 -> imm 0, fmt X, illegal=1.
//  Handshake:
//   - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
//   - in_ready = !skid_valid; it is a registered value with no combinational path from out_ready.
//   - Accept while output is empty or draining -> result goes to the output register.
//   - Accept while output is full and not draining -> result goes to skid; in_ready=0 next cycle.
//   - Output draining with skid full -> skid moves to output same edge; skid empties.
//   - Order is strictly FIFO.
//   - out_* are stable while out_valid=1 and out_ready=0.
//  Counter: illegal_cnt += 1 on each output transfer with out_illegal=1. It holds at 2^CNT_W-1. flush does not clear it.
//  Flush:
//   - Clears out_valid and skid_valid at the next edge.
//   - An input presented in the flush cycle is discarded, even if in_ready=1.
//   - An output transfer in the flush cycle still counts.
//   - in_ready=1 the cycle after flush.
//  rst mid-operation: all state returns to reset values immediately. The in-flight contents are lost.
// TESTING
//  1 XLEN=32, out_ready=1: IR 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0, tag echoed.
//  2 IR 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt 3. IR 0x123452B7 (lui) -> imm 0x12345000, fmt 4.
//    IR 0x01F09093 (slli 31) -> imm 0x1F, fmt 1.
//  3 XLEN=64: IR 0x800002B7 (lui 0x80000) -> imm 0xFFFFFFFF80000000.
//    IR 0x03F09093 (slli 63) -> imm 63. IR 0x0000901B (slliw) -> legal, imm 0.
//  4 Backpressure: out_ready=0, send tags 1,2,3 back-to-back.
//    -> tag1 held at output, tag2 in skid, in_ready=0, tag3 stalled.
//    Raise out_ready -> tags 1,2,3 delivered in order, one per cycle.
//  5 IR 0x00000000 and 0x0000007F -> fmt 7, illegal=1, imm 0, illegal_cnt=2.
//    Force the counter to all-ones, send another illegal -> counter stays at all-ones.
//  6 Output and skid full, pulse flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears.
//    Repeat with rst asserted mid-stall -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready handshake, a 2-entry skid buffer,
// a synchronous flush and a saturating counter of illegal results delivered.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_ir,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;
    localparam logic [2:0] FMT_X = 3'd7;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    logic [31:0]      w_raw;
    logic             w_sx;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic [XLEN-1:0]  w_imm;
    logic [31:0]      w_i_imm;
    logic [31:0]      w_shamt;
    logic [31:0]      w_shamt_w;
    logic             w_is_shift;
    logic             w_accept;
    logic             w_drain;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic [2:0]       r_out_fmt;
    logic             r_out_ill;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_ill;
    logic [TAG_W-1:0] r_skid_tag;
    logic [CNT_W-1:0] r_cnt;

    assign w_i_imm    = {{20{in_ir[31]}}, in_ir[31:20]};
    assign w_shamt    = (XLEN == 64) ? {26'b0, in_ir[25:20]} : {27'b0, in_ir[24:20]};
    assign w_shamt_w  = {27'b0, in_ir[24:20]};
    assign w_is_shift = (in_ir[13:12] == 2'b01);

    // w_raw holds a 32-bit value; w_sx selects sign or zero extension up to XLEN.
    always_comb begin
        w_raw = '0;
        w_sx  = 1'b0;
        w_fmt = FMT_X;
        w_ill = 1'b1;
        case (in_ir[6:0])
            OPC_OP_IMM: begin
                w_ill = 1'b0;
                w_fmt = FMT_I;
                w_raw = w_is_shift ? w_shamt : w_i_imm;
                w_sx  = !w_is_shift;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    w_ill = 1'b0;
                    w_fmt = FMT_I;
                    w_raw = w_is_shift ? w_shamt_w : w_i_imm;
                    w_sx  = !w_is_shift;
                end
            end
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                w_ill = 1'b0;
                w_fmt = FMT_I;
                w_raw = w_i_imm;
                w_sx  = 1'b1;
            end
            OPC_STORE: begin
                w_ill = 1'b0;
                w_fmt = FMT_S;
                w_raw = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                w_sx  = 1'b1;
            end
            OPC_BRANCH: begin
                w_ill = 1'b0;
                w_fmt = FMT_B;
                w_raw = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
                w_sx  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_ill = 1'b0;
                w_fmt = FMT_U;
                w_raw = {in_ir[31:12], 12'b0};
                w_sx  = 1'b1;
            end
            OPC_JAL: begin
                w_ill = 1'b0;
                w_fmt = FMT_J;
                w_raw = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
                w_sx  = 1'b1;
            end
            OPC_SYSTEM: begin
                w_ill = 1'b0;
                w_fmt = in_ir[14] ? FMT_Z : FMT_I;
                w_raw = in_ir[14] ? {27'b0, in_ir[19:15]} : {20'b0, in_ir[31:20]};
            end
            OPC_OP: begin
                w_ill = 1'b0;
                w_fmt = FMT_R;
            end
            OPC_OP_32: begin
                if (XLEN == 64) begin
                    w_ill = 1'b0;
                    w_fmt = FMT_R;
                end
            end
            default: ;
        endcase
    end

    assign w_imm    = w_sx ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
    assign w_accept = in_valid & ~r_skid_valid & ~flush;
    assign w_drain  = r_out_valid & out_ready;

    // Skid can only fill while the output register is held; it drains into the output first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_fmt    <= FMT_X;
            r_out_ill    <= 1'b0;
            r_out_tag    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FMT_X;
            r_skid_ill   <= 1'b0;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_fmt    <= r_skid_fmt;
                r_out_ill    <= r_skid_ill;
                r_out_tag    <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_imm;
                r_out_fmt   <= w_fmt;
                r_out_ill   <= w_ill;
                r_out_tag   <= in_tag;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_fmt   <= w_fmt;
            r_skid_ill   <= w_ill;
            r_skid_tag   <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain && r_out_ill && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready    = ~r_skid_valid;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_ill;
    assign out_tag     = r_out_tag;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives three imm_gen_pipe instances (XLEN=32, XLEN=64, XLEN=32 with a 2-bit counter) with
// identical stimulus and compares them against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ir;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        a_rdy, a_ov, a_ill;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic [7:0]  a_tag;
    logic [15:0] a_cnt;

    logic        b_rdy, b_ov, b_ill;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [7:0]  b_tag;
    logic [15:0] b_cnt;

    logic        c_rdy, c_ov, c_ill;
    logic [31:0] c_imm;
    logic [2:0]  c_fmt;
    logic [7:0]  c_tag;
    logic [1:0]  c_cnt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_ir(in_ir), .in_tag(in_tag), .out_valid(a_ov), .out_ready(out_ready),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill), .out_tag(a_tag),
        .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_ir(in_ir), .in_tag(in_tag), .out_valid(b_ov), .out_ready(out_ready),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_ill), .out_tag(b_tag),
        .illegal_cnt(b_cnt)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .in_ir(in_ir), .in_tag(in_tag), .out_valid(c_ov), .out_ready(out_ready),
        .out_imm(c_imm), .out_fmt(c_fmt), .out_illegal(c_ill), .out_tag(c_tag),
        .illegal_cnt(c_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] ir;
        logic [7:0]  tag;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt_a, m_cnt_b, m_cnt_c;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Reference decode written from the field definitions using integer arithmetic.
    function automatic void ref_dec(input logic [31:0] ir, input bit x64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint u = longint'(ir);
        longint f3 = (u >> 12) & 7;
        longint v = 0;
        bit     word_op = (ir[6:0] == 7'b0011011);
        fmt = 3'd7;
        ill = 1'b1;
        case (ir[6:0])
            7'b0010011, 7'b0011011: begin
                if (!word_op || x64) begin
                    ill = 0; fmt = 3'd1;
                    if (f3 == 1 || f3 == 5) v = (u >> 20) & ((x64 && !word_op) ? 63 : 31);
                    else v = sx(u >> 20, 12);
                end
            end
            7'b0000011, 7'b1100111, 7'b0001111: begin
                ill = 0; fmt = 3'd1; v = sx(u >> 20, 12);
            end
            7'b0100011: begin
                ill = 0; fmt = 3'd2; v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            end
            7'b1100011: begin
                ill = 0; fmt = 3'd3;
                v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                       (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            end
            7'b0110111, 7'b0010111: begin
                ill = 0; fmt = 3'd4; v = sx(u & 64'hFFFFF000, 32);
            end
            7'b1101111: begin
                ill = 0; fmt = 3'd5;
                v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                       (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            end
            7'b1110011: begin
                ill = 0;
                if (f3 >= 4) begin fmt = 3'd6; v = (u >> 15) & 31; end
                else begin fmt = 3'd1; v = u >> 20; end
            end
            7'b0110011: begin ill = 0; fmt = 3'd0; end
            7'b0111011: if (x64) begin ill = 0; fmt = 3'd0; end
            default: ;
        endcase
        if (ill) imm = '0;
        else imm = x64 ? v : (v & 64'hFFFFFFFF);
    endfunction

    task automatic model_edge();
        bit          acc = in_valid && (q.size() < 2) && !flush;
        logic [63:0] d_imm;
        logic [2:0]  d_fmt;
        logic        ill32, ill64;
        ent_t        e;
        if (q.size() > 0 && out_ready) begin
            ref_dec(q[0].ir, 1'b0, d_imm, d_fmt, ill32);
            ref_dec(q[0].ir, 1'b1, d_imm, d_fmt, ill64);
            if (ill32 && m_cnt_a < 65535) m_cnt_a++;
            if (ill64 && m_cnt_b < 65535) m_cnt_b++;
            if (ill32 && m_cnt_c < 3) m_cnt_c++;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) begin
            e.ir  = in_ir;
            e.tag = in_tag;
            q.push_back(e);
        end
    endtask

    task automatic compare_all();
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        logic        e_ov  = (q.size() > 0);
        logic        e_rdy = (q.size() < 2);
        check_eq("a_in_ready", a_rdy, e_rdy);
        check_eq("b_in_ready", b_rdy, e_rdy);
        check_eq("c_in_ready", c_rdy, e_rdy);
        check_eq("a_out_valid", a_ov, e_ov);
        check_eq("b_out_valid", b_ov, e_ov);
        check_eq("c_out_valid", c_ov, e_ov);
        if (e_ov) begin
            ref_dec(q[0].ir, 1'b0, e_imm, e_fmt, e_ill);
            check_eq("a_imm", a_imm, e_imm);
            check_eq("a_fmt", a_fmt, e_fmt);
            check_eq("a_ill", a_ill, e_ill);
            check_eq("a_tag", a_tag, q[0].tag);
            check_eq("c_imm", c_imm, e_imm);
            check_eq("c_tag", c_tag, q[0].tag);
            ref_dec(q[0].ir, 1'b1, e_imm, e_fmt, e_ill);
            check_eq("b_imm", b_imm, e_imm);
            check_eq("b_fmt", b_fmt, e_fmt);
            check_eq("b_ill", b_ill, e_ill);
            check_eq("b_tag", b_tag, q[0].tag);
        end
        check_eq("a_cnt", a_cnt, m_cnt_a);
        check_eq("b_cnt", b_cnt, m_cnt_b);
        check_eq("c_cnt", c_cnt, m_cnt_c);
    endtask

    // Called one time unit after a rising edge; returns at the same phase of the next cycle.
    task automatic cycle(input logic v, input logic [31:0] ir, input logic [7:0] tg,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_ir     = ir;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_reset_state();
        check_eq("rst_a_ov", a_ov, 1'b0);
        check_eq("rst_a_rdy", a_rdy, 1'b1);
        check_eq("rst_a_imm", a_imm, 32'h0);
        check_eq("rst_a_fmt", a_fmt, 3'd7);
        check_eq("rst_a_ill", a_ill, 1'b0);
        check_eq("rst_a_tag", a_tag, 8'h0);
        check_eq("rst_a_cnt", a_cnt, 16'h0);
        check_eq("rst_b_ov", b_ov, 1'b0);
        check_eq("rst_b_imm", b_imm, 64'h0);
        check_eq("rst_b_fmt", b_fmt, 3'd7);
        check_eq("rst_c_cnt", c_cnt, 2'd0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_state();
        q.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_cnt_c = 0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [14] = '{7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b0001111,
                            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                            7'b1110011, 7'b0110011, 7'b0111011, 7'b1111111};

    initial begin
        logic [31:0] r;
        logic [31:0] ir;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ir     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        m_cnt_a   = 0;
        m_cnt_b   = 0;
        m_cnt_c   = 0;
        #12 check_reset_state();
        rst = 1'b0;
        @(posedge clk);
        #1;

        cycle(1'b1, 32'hFFF00093, 8'h5A, 1'b1, 1'b0);
        check_eq("addi_imm", a_imm, 32'hFFFFFFFF);
        check_eq("addi_fmt", a_fmt, 3'd1);
        check_eq("addi_ill", a_ill, 1'b0);
        check_eq("addi_tag", a_tag, 8'h5A);
        cycle(1'b1, 32'hFE000EE3, 8'h01, 1'b1, 1'b0);
        check_eq("beq_imm", a_imm, 32'hFFFFFFFC);
        check_eq("beq_fmt", a_fmt, 3'd3);
        cycle(1'b1, 32'h123452B7, 8'h02, 1'b1, 1'b0);
        check_eq("lui_imm", a_imm, 32'h12345000);
        check_eq("lui_fmt", a_fmt, 3'd4);
        cycle(1'b1, 32'h01F09093, 8'h03, 1'b1, 1'b0);
        check_eq("slli31_imm", a_imm, 32'h1F);
        check_eq("slli31_fmt", a_fmt, 3'd1);
        cycle(1'b1, 32'h800002B7, 8'h04, 1'b1, 1'b0);
        check_eq("lui64_imm", b_imm, 64'hFFFFFFFF80000000);
        cycle(1'b1, 32'h03F09093, 8'h05, 1'b1, 1'b0);
        check_eq("slli63_imm", b_imm, 64'd63);
        cycle(1'b1, 32'h0000901B, 8'h06, 1'b1, 1'b0);
        check_eq("slliw64_ill", b_ill, 1'b0);
        check_eq("slliw64_imm", b_imm, 64'd0);
        check_eq("slliw32_ill", a_ill, 1'b1);
        check_eq("slliw32_fmt", a_fmt, 3'd7);
        cycle(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'hFFF00093, 8'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFF00093, 8'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFF00093, 8'd3, 1'b0, 1'b0);
        check_eq("bp_hold_tag", a_tag, 8'd1);
        check_eq("bp_in_ready", a_rdy, 1'b0);
        cycle(1'b1, 32'hFFF00093, 8'd3, 1'b1, 1'b0);
        check_eq("bp_tag2", a_tag, 8'd2);
        cycle(1'b1, 32'hFFF00093, 8'd3, 1'b1, 1'b0);
        check_eq("bp_tag3", a_tag, 8'd3);
        cycle(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
        check_eq("bp_empty", a_ov, 1'b0);

        do_reset();
        cycle(1'b1, 32'h00000000, 8'd7, 1'b1, 1'b0);
        check_eq("ill0_fmt", a_fmt, 3'd7);
        check_eq("ill0_ill", a_ill, 1'b1);
        check_eq("ill0_imm", a_imm, 32'h0);
        cycle(1'b1, 32'h0000007F, 8'd8, 1'b1, 1'b0);
        check_eq("ill7f_ill", a_ill, 1'b1);
        cycle(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
        check_eq("cnt_two", a_cnt, 16'd2);
        check_eq("cnt_two_c", c_cnt, 2'd2);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0000007F, 8'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
        check_eq("cnt_five", a_cnt, 16'd5);
        check_eq("cnt_sat", c_cnt, 2'd3);

        cycle(1'b1, 32'h12345037, 8'd10, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345037, 8'd11, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345037, 8'd12, 1'b0, 1'b1);
        check_eq("flush_ov", a_ov, 1'b0);
        check_eq("flush_rdy", a_rdy, 1'b1);
        cycle(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
        check_eq("flush_dropped", a_ov, 1'b0);
        cycle(1'b1, 32'h12345037, 8'd20, 1'b0, 1'b0);
        cycle(1'b1, 32'h12345037, 8'd21, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 7) == 0) ir = r;
            else ir = {r[31:7], ops[$urandom_range(0, 13)]};
            cycle(($urandom_range(0, 9) < 7), ir, 8'($urandom()),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
